rtc_timekeeper: RTL and testbench
=================================

# rtc_timekeeper

DS1307-compatible timekeeping core for the RTC. Divides the system clock to a 1 Hz tick and maintains the BCD time/date/control registers 0x00–0x07. These eight bytes drive the I2C register interface's `Reg0`–`Reg7` inputs. I2C writes to addresses 0x00–0x07, which the register interface does not store, are applied here.

## Interface
Parameters:
- `CLK_HZ`, default 28000000: system clock frequency; the prescaler divides by this value.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `addr`  in  6  I2C register address; same bus that feeds the register interface.
- `dataIn`  in  8  I2C write data.
- `writeEn`  in  1  one-cycle write strobe; only addresses 0x00–0x07 are accepted.
- `Reg0`–`Reg7`  out  8 each  seconds, minutes, hours, day, date, month, year, control.
- `tick1hz`  out  1  one-cycle pulse on each counted second.
- `sqw`  out  1  square-wave / OUT pin.

## Operation
- All outputs are registered. Reset values:
  - `Reg0`=0x80 (CH=1, clock halted)
  - `Reg1`=0x00, `Reg2`=0x00 (24 h mode)
  - `Reg3`=0x01, `Reg4`=0x01, `Reg5`=0x01, `Reg6`=0x00
  - `Reg7`=0x03
  - `tick1hz`=0, `sqw`=0
  - prescaler=0
- Prescaler:
  - Counts 0..CLK_HZ-1 while CH (`Reg0[7]`)=0.
  - Raises an internal tick at terminal count, then wraps to 0.
  - CH=1 holds the prescaler at 0 and produces no ticks.
- Tick cascade, all updated on the same edge, BCD arithmetic:
  - Seconds 00–59; carry into minutes.
  - Minutes 00–59; carry into hours.
  - Hours in 24 h mode (`Reg2[6]`=0): 00–23; 23→00 carries into day/date.
  - Hours in 12 h mode (`Reg2[6]`=1): bit5 is PM, bits4:0 hold 01–12.
    - 11→12 toggles PM.
    - 12→01 keeps PM.
    - Day/date carry only on the PM→AM transition (11 PM→12 AM).
  - Day 1–7; 7→1.
  - Date 01..last, where last = 31/30/28/29 by month.
    - Leap year = BCD year divisible by 4 (00 counts as leap).
  - Month 01–12; 12→01 carries into year.
  - Year 00–99; wraps to 00.
- Rollover rules:
  - Any field at or above its limit rolls to its minimum on a tick, whether the value is BCD-valid or not.
  - A BCD low digit ≥9 carries into the tens digit.
- Register writes (`writeEn`=1, `addr`≤0x07) store `dataIn` with unused bits forced to 0:
  - `Reg2[7]`, `Reg3[7:3]`, `Reg4[7:6]`, `Reg5[7:5]`, `Reg7[6:5]`, `Reg7[3:2]`.
  - Values are not range-checked.
  - A write to `addr`=0x00 also clears the prescaler to 0.
- Write/tick collision, same cycle:
  - Write to 0x00: the write wins and the tick is discarded.
  - Write to 0x01–0x07: the written register takes `dataIn`, and the whole tick cascade is deferred exactly one cycle. It then runs using the newly written value.
- `sqw` (control = `Reg7`: OUT bit7, SQWE bit4, RS bits1:0):
  - SQWE=0: `sqw`=OUT.
  - SQWE=1, CH=0: square wave at 1 Hz / 4096 / 8192 / 32768 Hz for RS=00/01/10/11.
  - Each wave uses an independent half-period divider of round(CLK_HZ/(2f)) cycles.
  - The RS=00 wave is phase-locked to the prescaler: high for prescaler < CLK_HZ/2.
  - SQWE=1, CH=1: `sqw` held 0.
  - A write to `Reg7` restarts the half-period divider.

## Timing
- Write latency: the register shows `dataIn` on the edge after `writeEn`.
- The tick and all register increments land on the same edge.
- `tick1hz` is high for the cycle following the register update.
- First tick after CH is cleared: CLK_HZ cycles after the write edge.
- Deferred tick (write to 0x01–0x07 in a tick cycle):
  - Increments land one cycle later than normal.
  - `tick1hz` is also delayed one cycle.
  - The prescaler phase is unaffected.
- `rst` mid-second: prescaler, registers and `sqw` return to their reset values on that edge; a pending deferred tick is dropped.
- `sqw` changes only on `clk` edges; jitter ≤1 cycle.

## Test plan
- Reset with CLK_HZ=16: outputs match the reset values.
- CH stays 1 for 100 cycles: `Reg0` stays 0x80 and there are no ticks.
- Write 0x00 to 0x00, then wait 16 cycles: `Reg0`=0x01 and `tick1hz` pulses once.
- 24 h rollover: preset 23:59:59, date 0x31/12/99, day 7. One tick → 00:00:00, day 1, date 01, month 01, year 00.
- 12 h rollover:
  - Preset hours 0x71 (11 PM), 59:59. Tick → hours 0x52 (12 AM) and date increments.
  - Preset 0x52. Tick at 59:59 → hours 0x41 with no date change.
- Leap year:
  - Preset year 0x24, month 0x02, date 0x28, 23:59:59. Tick → date 0x29.
  - Next day rollover → 0x01 / month 0x03.
  - Repeat with year 0x23: 0x28 → 0x01.
- Collisions:
  - Write `Reg1`=0x30 on the tick cycle with seconds 0x59. One cycle later: seconds 0x00, minutes 0x31.
  - Write 0x00 to 0x00 on the tick cycle: seconds 0x00, no tick, and the next tick arrives CLK_HZ cycles later.
- `sqw`:
  - `Reg7`=0x10: period CLK_HZ cycles, high for the first half.
  - `Reg7`=0x80: `sqw`=1 constant.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper
//   DS1307-style timekeeping core. Divides clk down to a 1 Hz tick and keeps
//   the BCD time/date/control registers 0x00-0x07 that the I2C register
//   interface exposes; I2C writes to those addresses are applied here.
//
//   Ports
//     clk, rst        system clock, synchronous active-high reset
//     addr, dataIn    I2C register address / write data
//     writeEn         one-cycle write strobe (addresses 0x00-0x07 only)
//     Reg0..Reg7      seconds, minutes, hours, day, date, month, year, control
//     tick1hz         one-cycle pulse after each counted second
//     sqw             square-wave / OUT pin
module rtc_timekeeper #(
    parameter int unsigned CLK_HZ = 28000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] addr,
    input  logic [7:0] dataIn,
    input  logic       writeEn,
    output logic [7:0] Reg0,
    output logic [7:0] Reg1,
    output logic [7:0] Reg2,
    output logic [7:0] Reg3,
    output logic [7:0] Reg4,
    output logic [7:0] Reg5,
    output logic [7:0] Reg6,
    output logic [7:0] Reg7,
    output logic       tick1hz,
    output logic       sqw
);

    // Half period in clk cycles for a wave of frequency f, rounded, at least 1.
    function automatic int unsigned half_cycles(input int unsigned f);
        int unsigned h;
        h = (CLK_HZ + f) / (2 * f);
        return (h == 0) ? 1 : h;
    endfunction

    localparam int unsigned PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PTERM = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PHALF = PW'(CLK_HZ / 2);
    localparam int unsigned H4K   = half_cycles(4096);
    localparam int unsigned H8K   = half_cycles(8192);
    localparam int unsigned H32K  = half_cycles(32768);
    localparam int unsigned DW    = $clog2(H4K) + 1;

    // BCD increment: a low digit of 9 or more carries into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] >= 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction

    // Anything at or above the limit wraps to the minimum, valid BCD or not.
    function automatic logic [7:0] roll(input logic [7:0] v, input logic [7:0] lim,
                                        input logic [7:0] min);
        return (v >= lim) ? min : bcd_inc(v);
    endfunction

    logic [PW-1:0] presc, presc_nxt;
    logic          deferred, defer_nxt;
    logic          wr, wr0, wr7, tick_int, pending, do_tick;
    logic          c_min, c_hr, c_day, c_mon, c_yr, leap, pm;
    logic [7:0]    sec, hr, hn, dy, dt, mo, last_date;
    logic [7:0]    r0_t, r1_t, r2_t, r3_t, r4_t, r5_t, r6_t;
    logic [7:0]    reg7_nxt;
    logic          ch_nxt, wave, wave_nxt, sqw_nxt;
    logic [DW-1:0] div_cnt, div_nxt, half_sel;

    always_comb begin
        wr        = writeEn && (addr[5:3] == 3'b000);
        wr0       = wr && (addr[2:0] == 3'd0);
        wr7       = wr && (addr[2:0] == 3'd7);
        tick_int  = !Reg0[7] && (presc == PTERM);
        // A tick colliding with a write to 0x01-0x07 is held for one cycle;
        // a write to 0x00 discards it.
        pending   = tick_int || deferred;
        do_tick   = pending && !wr;
        defer_nxt = pending && wr && !wr0;

        if (wr0 || Reg0[7] || tick_int) presc_nxt = '0;
        else                            presc_nxt = presc + PW'(1);

        // Cascade from the currently stored values.
        sec   = {1'b0, Reg0[6:0]};
        c_min = sec >= 8'h59;
        r0_t  = (Reg0 & 8'h80) | (roll(sec, 8'h59, 8'h00) & 8'h7F);

        c_hr  = c_min && (Reg1 >= 8'h59);
        r1_t  = c_min ? roll(Reg1, 8'h59, 8'h00) : Reg1;

        if (Reg2[6]) begin
            // 12 h: only 11 PM -> 12 AM advances the date.
            hr    = {3'b000, Reg2[4:0]};
            hn    = roll(hr, 8'h12, 8'h01);
            pm    = Reg2[5] ^ (hr == 8'h11);
            r2_t  = c_hr ? ({2'b01, pm, 5'b00000} | (hn & 8'h1F)) : Reg2;
            c_day = c_hr && (hr == 8'h11) && Reg2[5];
        end else begin
            hr    = {2'b00, Reg2[5:0]};
            hn    = roll(hr, 8'h23, 8'h00);
            pm    = 1'b0;
            r2_t  = c_hr ? (hn & 8'h3F) : Reg2;
            c_day = c_hr && (hr >= 8'h23);
        end

        dy   = {5'b00000, Reg3[2:0]};
        r3_t = c_day ? (roll(dy, 8'h07, 8'h01) & 8'h07) : Reg3;

        // BCD year divisible by 4: (10*tens + ones) mod 4 == (2*tens[0] + ones) mod 4.
        leap = !Reg6[0] && (Reg6[1] == Reg6[4]);
        mo   = {3'b000, Reg5[4:0]};
        case (mo)
            8'h02:                      last_date = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: last_date = 8'h30;
            default:                    last_date = 8'h31;
        endcase

        dt    = {2'b00, Reg4[5:0]};
        c_mon = c_day && (dt >= last_date);
        r4_t  = c_day ? (roll(dt, last_date, 8'h01) & 8'h3F) : Reg4;

        c_yr  = c_mon && (mo >= 8'h12);
        r5_t  = c_mon ? (roll(mo, 8'h12, 8'h01) & 8'h1F) : Reg5;
        r6_t  = c_yr ? roll(Reg6, 8'h99, 8'h00) : Reg6;

        // Square wave, computed from next-state values so sqw is registered
        // in step with the registers and prescaler.
        reg7_nxt = wr7 ? (dataIn & 8'h93) : Reg7;
        ch_nxt   = wr0 ? dataIn[7] : Reg0[7];
        case (Reg7[1:0])
            2'b10:   half_sel = DW'(H8K - 1);
            2'b11:   half_sel = DW'(H32K - 1);
            default: half_sel = DW'(H4K - 1);
        endcase
        if (wr7 || ch_nxt || !Reg7[4]) begin
            div_nxt  = '0;
            wave_nxt = 1'b0;
        end else if (div_cnt >= half_sel) begin
            div_nxt  = '0;
            wave_nxt = !wave;
        end else begin
            div_nxt  = div_cnt + DW'(1);
            wave_nxt = wave;
        end
        if (!reg7_nxt[4])              sqw_nxt = reg7_nxt[7];
        else if (ch_nxt)               sqw_nxt = 1'b0;
        else if (reg7_nxt[1:0] == 2'b00) sqw_nxt = (presc_nxt < PHALF);
        else                           sqw_nxt = wave_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            deferred <= 1'b0;
            tick1hz  <= 1'b0;
            sqw      <= 1'b0;
            div_cnt  <= '0;
            wave     <= 1'b0;
            Reg0     <= 8'h80;
            Reg1     <= 8'h00;
            Reg2     <= 8'h00;
            Reg3     <= 8'h01;
            Reg4     <= 8'h01;
            Reg5     <= 8'h01;
            Reg6     <= 8'h00;
            Reg7     <= 8'h03;
        end else begin
            presc    <= presc_nxt;
            deferred <= defer_nxt;
            tick1hz  <= do_tick;
            sqw      <= sqw_nxt;
            div_cnt  <= div_nxt;
            wave     <= wave_nxt;
            if (wr) begin
                case (addr[2:0])
                    3'd0:    Reg0 <= dataIn;
                    3'd1:    Reg1 <= dataIn;
                    3'd2:    Reg2 <= dataIn & 8'h7F;
                    3'd3:    Reg3 <= dataIn & 8'h07;
                    3'd4:    Reg4 <= dataIn & 8'h3F;
                    3'd5:    Reg5 <= dataIn & 8'h1F;
                    3'd6:    Reg6 <= dataIn;
                    default: Reg7 <= dataIn & 8'h93;
                endcase
            end else if (do_tick) begin
                Reg0 <= r0_t;
                Reg1 <= r1_t;
                Reg2 <= r2_t;
                Reg3 <= r3_t;
                Reg4 <= r4_t;
                Reg5 <= r5_t;
                Reg6 <= r6_t;
            end
        end
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper
//   Directed bench for rtc_timekeeper at CLK_HZ=16. Inputs change and outputs
//   are sampled on the falling edge of clk.
module tb_rtc_timekeeper;

    localparam int unsigned HZ = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       writeEn = 1'b0;
    logic [5:0] addr = '0;
    logic [7:0] dataIn = '0;
    logic [7:0] Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, Reg7;
    logic       tick1hz, sqw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtc_timekeeper #(.CLK_HZ(HZ)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .dataIn  (dataIn),
        .writeEn (writeEn),
        .Reg0    (Reg0),
        .Reg1    (Reg1),
        .Reg2    (Reg2),
        .Reg3    (Reg3),
        .Reg4    (Reg4),
        .Reg5    (Reg5),
        .Reg6    (Reg6),
        .Reg7    (Reg7),
        .tick1hz (tick1hz),
        .sqw     (sqw)
    );

    // Called at a falling edge; returns at the falling edge after the write edge.
    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        addr    = a;
        dataIn  = d;
        writeEn = 1'b1;
        @(negedge clk);
        writeEn = 1'b0;
    endtask

    // Halt, load minutes..year, then load seconds with CH=0 (starts the second).
    task automatic preset(input logic [55:0] v);
        wr(6'd0, 8'h80);
        wr(6'd1, v[47:40]);
        wr(6'd2, v[39:32]);
        wr(6'd3, v[31:24]);
        wr(6'd4, v[23:16]);
        wr(6'd5, v[15:8]);
        wr(6'd6, v[7:0]);
        wr(6'd0, v[55:48] & 8'h7F);
    endtask

    task automatic tick_from(input logic [55:0] v);
        preset(v);
        repeat (HZ) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, Reg7} !== 64'h80000001010100_03) begin
            errors++;
            $display("FAIL reset_regs: got %h expected %h",
                     {Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, Reg7}, 64'h8000000101010003);
        end
        checks++;
        if ({tick1hz, sqw} !== 2'b00) begin
            errors++;
            $display("FAIL reset_tick_sqw: got %b expected 00", {tick1hz, sqw});
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({Reg0, tick1hz} !== {8'h80, 1'b0}) begin
                errors++;
                $display("FAIL halt_cycle%0d: got %h/%b expected 80/0", i, Reg0, tick1hz);
            end
        end
    endtask

    task automatic test_start();
        logic [8:0] exp;
        wr(6'd0, 8'h00);
        for (int i = 1; i <= HZ + 1; i++) begin
            @(negedge clk);
            exp = {(i >= HZ) ? 8'h01 : 8'h00, i == HZ};
            checks++;
            if ({Reg0, tick1hz} !== exp) begin
                errors++;
                $display("FAIL start_cycle%0d: got %h/%b expected %h/%b",
                         i, Reg0, tick1hz, exp[8:1], exp[0]);
            end
        end
    endtask

    // Vectors: {sec,min,hour,day,date,month,year} before and after one tick.
    task automatic test_rollover_24h();
        logic [55:0] pre [4];
        logic [55:0] exp [4];
        pre = '{56'h59_59_23_07_31_12_99, 56'h09_15_08_02_09_01_09,
                56'h59_59_09_02_09_01_09, 56'h7F_20_12_02_09_01_09};
        exp = '{56'h00_00_00_01_01_01_00, 56'h10_15_08_02_09_01_09,
                56'h00_00_10_02_09_01_09, 56'h00_21_12_02_09_01_09};
        for (int i = 0; i < 4; i++) begin
            tick_from(pre[i]);
            checks++;
            if ({Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, tick1hz} !== {exp[i], 1'b1}) begin
                errors++;
                $display("FAIL roll24_%0d: got %h/%b expected %h/1", i,
                         {Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6}, tick1hz, exp[i]);
            end
        end
    endtask

    task automatic test_rollover_12h();
        logic [55:0] pre [4];
        logic [55:0] exp [4];
        pre = '{56'h59_59_71_02_15_06_10, 56'h59_59_52_03_16_06_10,
                56'h59_59_51_03_16_06_10, 56'h59_59_72_03_16_06_10};
        exp = '{56'h00_00_52_03_16_06_10, 56'h00_00_41_03_16_06_10,
                56'h00_00_72_03_16_06_10, 56'h00_00_61_03_16_06_10};
        for (int i = 0; i < 4; i++) begin
            tick_from(pre[i]);
            checks++;
            if ({Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, tick1hz} !== {exp[i], 1'b1}) begin
                errors++;
                $display("FAIL roll12_%0d: got %h/%b expected %h/1", i,
                         {Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6}, tick1hz, exp[i]);
            end
        end
    endtask

    task automatic test_calendar();
        logic [55:0] pre [8];
        logic [55:0] exp [8];
        pre = '{56'h59_59_23_03_28_02_24, 56'h59_59_23_04_29_02_24,
                56'h59_59_23_05_28_02_23, 56'h59_59_23_06_28_02_00,
                56'h59_59_23_07_30_04_23, 56'h59_59_23_01_30_05_23,
                56'h59_59_23_03_30_09_19, 56'h59_59_23_03_31_12_19};
        exp = '{56'h00_00_00_04_29_02_24, 56'h00_00_00_05_01_03_24,
                56'h00_00_00_06_01_03_23, 56'h00_00_00_07_29_02_00,
                56'h00_00_00_01_01_05_23, 56'h00_00_00_02_31_05_23,
                56'h00_00_00_04_01_10_19, 56'h00_00_00_04_01_01_20};
        for (int i = 0; i < 8; i++) begin
            tick_from(pre[i]);
            checks++;
            if ({Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, tick1hz} !== {exp[i], 1'b1}) begin
                errors++;
                $display("FAIL calendar_%0d: got %h/%b expected %h/1", i,
                         {Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6}, tick1hz, exp[i]);
            end
        end
    endtask

    task automatic test_collision_reg1();
        preset(56'h59_10_05_01_01_01_00);
        repeat (HZ - 1) @(negedge clk);
        wr(6'd1, 8'h30);
        checks++;
        if ({Reg0, Reg1, tick1hz} !== {8'h59, 8'h30, 1'b0}) begin
            errors++;
            $display("FAIL col1_write: got %h %h %b expected 59 30 0", Reg0, Reg1, tick1hz);
        end
        @(negedge clk);
        checks++;
        if ({Reg0, Reg1, tick1hz} !== {8'h00, 8'h31, 1'b1}) begin
            errors++;
            $display("FAIL col1_deferred: got %h %h %b expected 00 31 1", Reg0, Reg1, tick1hz);
        end
        repeat (HZ - 2) @(negedge clk);
        checks++;
        if ({Reg0, tick1hz} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL col1_before_next: got %h %b expected 00 0", Reg0, tick1hz);
        end
        @(negedge clk);
        checks++;
        if ({Reg0, tick1hz} !== {8'h01, 1'b1}) begin
            errors++;
            $display("FAIL col1_next_tick: got %h %b expected 01 1", Reg0, tick1hz);
        end
    endtask

    task automatic test_collision_reg0();
        logic [8:0] exp;
        preset(56'h59_10_05_01_01_01_00);
        repeat (HZ - 1) @(negedge clk);
        wr(6'd0, 8'h00);
        checks++;
        if ({Reg0, Reg1, tick1hz} !== {8'h00, 8'h10, 1'b0}) begin
            errors++;
            $display("FAIL col0_write: got %h %h %b expected 00 10 0", Reg0, Reg1, tick1hz);
        end
        for (int i = 1; i <= HZ; i++) begin
            @(negedge clk);
            exp = {(i == HZ) ? 8'h01 : 8'h00, i == HZ};
            checks++;
            if ({Reg0, tick1hz} !== exp) begin
                errors++;
                $display("FAIL col0_cycle%0d: got %h/%b expected %h/%b",
                         i, Reg0, tick1hz, exp[8:1], exp[0]);
            end
        end
    endtask

    task automatic test_sqw();
        bit found = 1'b0;
        wr(6'd0, 8'h00);
        wr(6'd7, 8'h10);
        for (int n = 0; n < 3 * HZ && !found; n++) begin
            @(negedge clk);
            if (tick1hz === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL sqw_sync: got no tick1hz within %0d cycles, required one", 3 * HZ);
        end
        for (int i = 0; i < 2 * HZ; i++) begin
            checks++;
            if (sqw !== ((i % HZ) < HZ / 2)) begin
                errors++;
                $display("FAIL sqw_1hz_phase%0d: got %b expected %b", i, sqw, (i % HZ) < HZ / 2);
            end
            @(negedge clk);
        end
        wr(6'd7, 8'h80);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (sqw !== 1'b1) begin
                errors++;
                $display("FAIL sqw_out_high%0d: got %b expected 1", i, sqw);
            end
            @(negedge clk);
        end
        wr(6'd7, 8'h00);
        checks++;
        if (sqw !== 1'b0) begin
            errors++;
            $display("FAIL sqw_out_low: got %b expected 0", sqw);
        end
        wr(6'd0, 8'h80);
        wr(6'd7, 8'h10);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (sqw !== 1'b0) begin
                errors++;
                $display("FAIL sqw_halted%0d: got %b expected 0", i, sqw);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_mask();
        wr(6'd0, 8'hA5);
        for (int a = 1; a < 8; a++) wr(6'(a), 8'hFF);
        checks++;
        if ({Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, Reg7} !== 64'hA5FF7F073F1FFF93) begin
            errors++;
            $display("FAIL write_mask: got %h expected %h",
                     {Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, Reg7}, 64'hA5FF7F073F1FFF93);
        end
        wr(6'h08, 8'h00);
        wr(6'h3F, 8'h00);
        checks++;
        if ({Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, Reg7} !== 64'hA5FF7F073F1FFF93) begin
            errors++;
            $display("FAIL write_out_of_range: got %h expected %h",
                     {Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, Reg7}, 64'hA5FF7F073F1FFF93);
        end
    endtask

    task automatic test_reset_mid();
        wr(6'd7, 8'h80);
        preset(56'h59_10_05_01_01_01_00);
        repeat (HZ - 1) @(negedge clk);
        wr(6'd1, 8'h30);
        checks++;
        if ({Reg1, sqw} !== {8'h30, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_before: got %h %b expected 30 1", Reg1, sqw);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, Reg7, tick1hz, sqw}
                    !== {64'h8000000101010003, 2'b00}) begin
                errors++;
                $display("FAIL rstmid_%0d: got %h/%b%b expected 8000000101010003/00", i,
                         {Reg0, Reg1, Reg2, Reg3, Reg4, Reg5, Reg6, Reg7}, tick1hz, sqw);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_start();
        test_rollover_24h();
        test_rollover_12h();
        test_calendar();
        test_collision_reg1();
        test_collision_reg0();
        test_sqw();
        test_write_mask();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
